// File: rtl/corescore_mmcm_rst_ctrl.sv
// MMCM reset/lock controller: pulses the MMCM reset, waits for lock with timeout
// and retry, and holds the system reset until lock has been stable for a settle window.
module corescore_mmcm_rst_ctrl #(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 17
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_locked,
    output logic       o_mmcm_rst,
    output logic       o_rst,
    output logic [7:0] o_retries
);

    typedef enum logic [1:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_SETTLE,
        S_RUN
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_retry;
    logic             r_locked_meta;
    logic             r_locked_s;
    logic             r_mmcm_rst;
    logic             r_rst;
    logic [7:0]       r_retries;

    // Next-state logic; a single counter is shared by the reset pulse, lock timeout and settle window.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_retry      = 1'b0;
        case (r_state)
            S_RESET: begin
                if (r_cnt == RST_LAST) begin
                    w_next_state = S_WAIT_LOCK;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_next_state = S_SETTLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_next_state = S_RESET;
                    w_next_cnt   = '0;
                    w_retry      = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                // A dropout while settling restarts the lock wait but is not counted as a retry.
                if (!r_locked_s) begin
                    w_next_state = S_WAIT_LOCK;
                    w_next_cnt   = '0;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!r_locked_s) begin
                    w_next_state = S_RESET;
                    w_next_cnt   = '0;
                    w_retry      = 1'b1;
                end
            end
            default: begin
                w_next_state = S_RESET;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they switch on the transition edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RESET;
            r_cnt         <= '0;
            r_locked_meta <= 1'b0;
            r_locked_s    <= 1'b0;
            r_mmcm_rst    <= 1'b1;
            r_rst         <= 1'b1;
            r_retries     <= 8'd0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_next_cnt;
            r_locked_meta <= i_locked;
            r_locked_s    <= r_locked_meta;
            r_mmcm_rst    <= (w_next_state == S_RESET);
            r_rst         <= (w_next_state != S_RUN);
            if (w_retry && (r_retries != 8'hFF)) begin
                r_retries <= r_retries + 8'd1;
            end
        end
    end

    assign o_mmcm_rst = r_mmcm_rst;
    assign o_rst      = r_rst;
    assign o_retries  = r_retries;

endmodule

// File: tb/tb_corescore_mmcm_rst_ctrl.sv
// Directed testbench for corescore_mmcm_rst_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=100,
// SETTLE_CYCLES=8; edge numbers are counted from the first edge with i_rst low.
module tb_corescore_mmcm_rst_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_locked;
    logic       o_mmcm_rst;
    logic       o_rst;
    logic [7:0] o_retries;

    int edgeNum     = 0;
    int assertCount = 0;
    int failCount   = 0;
    int base        = 0;

    corescore_mmcm_rst_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .SETTLE_CYCLES(8),
        .CNT_W        (8)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_locked  (i_locked),
        .o_mmcm_rst(o_mmcm_rst),
        .o_rst     (o_rst),
        .o_retries (o_retries)
    );

    always #5 i_clk = ~i_clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
        edgeNum++;
    endtask

    task automatic stepTo(input int n);
        while (edgeNum < n) tick();
    endtask

    task automatic applyStimulus(input logic rst, input logic locked);
        i_rst    = rst;
        i_locked = locked;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d at edge %0d", tag, observed, expected, edgeNum);
        end
    endtask

    // Fresh reset release followed by a lock sampled at edge 20; expects RUN at edge 30.
    task automatic runNormalLock(input string pfx);
        stepTo(0);
        checkOutput({pfx, "_mmcm_e0"}, {7'd0, o_mmcm_rst}, 8'd1);
        stepTo(2);
        checkOutput({pfx, "_mmcm_e2"}, {7'd0, o_mmcm_rst}, 8'd1);
        stepTo(3);
        checkOutput({pfx, "_mmcm_e3"}, {7'd0, o_mmcm_rst}, 8'd0);
        checkOutput({pfx, "_rst_e3"}, {7'd0, o_rst}, 8'd1);
        stepTo(19);
        applyStimulus(1'b0, 1'b1);
        stepTo(29);
        checkOutput({pfx, "_rst_e29"}, {7'd0, o_rst}, 8'd1);
        stepTo(30);
        checkOutput({pfx, "_rst_e30"}, {7'd0, o_rst}, 8'd0);
        checkOutput({pfx, "_mmcm_e30"}, {7'd0, o_mmcm_rst}, 8'd0);
        checkOutput({pfx, "_retries_e30"}, o_retries, 8'd0);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0);
        tick();
        tick();
        checkOutput("reset_mmcm", {7'd0, o_mmcm_rst}, 8'd1);
        checkOutput("reset_rst", {7'd0, o_rst}, 8'd1);
        checkOutput("reset_retries", o_retries, 8'd0);

        // Scenario 1: normal lock
        applyStimulus(1'b0, 1'b0);
        edgeNum = -1;
        runNormalLock("s1");

        // Scenario 4: lock loss in RUN, sampled low at edge 40
        stepTo(39);
        applyStimulus(1'b0, 1'b0);
        stepTo(41);
        checkOutput("s4_rst_f1", {7'd0, o_rst}, 8'd0);
        stepTo(42);
        checkOutput("s4_rst_f2", {7'd0, o_rst}, 8'd1);
        checkOutput("s4_mmcm_f2", {7'd0, o_mmcm_rst}, 8'd1);
        checkOutput("s4_retries", o_retries, 8'd1);
        applyStimulus(1'b0, 1'b1);
        stepTo(45);
        checkOutput("s4_mmcm_e45", {7'd0, o_mmcm_rst}, 8'd1);
        stepTo(46);
        checkOutput("s4_mmcm_e46", {7'd0, o_mmcm_rst}, 8'd0);
        stepTo(54);
        checkOutput("s4_rst_e54", {7'd0, o_rst}, 8'd1);
        stepTo(55);
        checkOutput("s4_rst_e55", {7'd0, o_rst}, 8'd0);

        // Four more lock losses to bring the retry count to 5
        for (int k = 0; k < 4; k++) begin
            base = edgeNum;
            applyStimulus(1'b0, 1'b0);
            stepTo(base + 3);
            applyStimulus(1'b0, 1'b1);
            stepTo(base + 16);
        end
        checkOutput("loop_retries", o_retries, 8'd5);
        checkOutput("loop_rst", {7'd0, o_rst}, 8'd0);

        // Scenario 6: one-cycle reset in RUN
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("s6_rst", {7'd0, o_rst}, 8'd1);
        checkOutput("s6_mmcm", {7'd0, o_mmcm_rst}, 8'd1);
        checkOutput("s6_retries", o_retries, 8'd0);
        applyStimulus(1'b0, 1'b0);
        edgeNum = -1;
        runNormalLock("s6");

        // Scenario 3: two-cycle dropout during SETTLE after a lock loss
        base = edgeNum;
        applyStimulus(1'b0, 1'b0);
        stepTo(base + 3);
        checkOutput("s3_retries_loss", o_retries, 8'd1);
        applyStimulus(1'b0, 1'b1);
        stepTo(base + 8);
        checkOutput("s3_settle_rst", {7'd0, o_rst}, 8'd1);
        checkOutput("s3_settle_mmcm", {7'd0, o_mmcm_rst}, 8'd0);
        stepTo(base + 9);
        applyStimulus(1'b0, 1'b0);
        stepTo(base + 11);
        applyStimulus(1'b0, 1'b1);
        stepTo(base + 12);
        checkOutput("s3_glitch_rst", {7'd0, o_rst}, 8'd1);
        checkOutput("s3_glitch_mmcm", {7'd0, o_mmcm_rst}, 8'd0);
        stepTo(base + 16);
        checkOutput("s3_no_early_run", {7'd0, o_rst}, 8'd1);
        stepTo(base + 21);
        checkOutput("s3_rst_e9", {7'd0, o_rst}, 8'd1);
        stepTo(base + 22);
        checkOutput("s3_rst_e10", {7'd0, o_rst}, 8'd0);
        checkOutput("s3_retries", o_retries, 8'd1);

        // Scenarios 2 and 5: no lock, timeouts at edges 104k-1
        applyStimulus(1'b1, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0);
        edgeNum = -1;
        stepTo(102);
        checkOutput("s2_mmcm_e102", {7'd0, o_mmcm_rst}, 8'd0);
        checkOutput("s2_retries_e102", o_retries, 8'd0);
        stepTo(103);
        checkOutput("s2_mmcm_e103", {7'd0, o_mmcm_rst}, 8'd1);
        checkOutput("s2_retries_e103", o_retries, 8'd1);
        checkOutput("s2_rst_e103", {7'd0, o_rst}, 8'd1);
        stepTo(106);
        checkOutput("s2_mmcm_e106", {7'd0, o_mmcm_rst}, 8'd1);
        stepTo(107);
        checkOutput("s2_mmcm_e107", {7'd0, o_mmcm_rst}, 8'd0);
        stepTo(206);
        checkOutput("s2_retries_e206", o_retries, 8'd1);
        stepTo(207);
        checkOutput("s2_retries_e207", o_retries, 8'd2);
        checkOutput("s2_mmcm_e207", {7'd0, o_mmcm_rst}, 8'd1);
        stepTo(311);
        checkOutput("s2_retries_e311", o_retries, 8'd3);
        checkOutput("s2_rst_e311", {7'd0, o_rst}, 8'd1);
        stepTo(104 * 254 - 1);
        checkOutput("s5_retries_254", o_retries, 8'd254);
        stepTo(104 * 255 - 1);
        checkOutput("s5_retries_255", o_retries, 8'd255);
        stepTo(104 * 300 - 1);
        checkOutput("s5_retries_sat", o_retries, 8'd255);
        checkOutput("s5_mmcm", {7'd0, o_mmcm_rst}, 8'd1);
        checkOutput("s5_rst", {7'd0, o_rst}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
